ac_mem_clear: RTL and testbench
===============================

# ac_mem_clear

Memory clear engine that sits directly downstream of the autoclear register block: it consumes one `o_AC_Start` bit and returns the matching `i_AC_Done` pulse. On a start request it walks a RAM write port from address 0 to `LAST_ADDR`, writing `CLEAR_VALUE` to each location. While idle it passes a user write channel straight through to the RAM, and it stalls that channel while a clear is in progress. A deasserted start mid-clear (the autoclear stop register) aborts the walk without a done pulse.

## Interface
- `ADDR_WIDTH`, 8, RAM address width.
- `DATA_WIDTH`, 16, RAM data width.
- `LAST_ADDR`, 2**ADDR_WIDTH-1, final address cleared; must be ≤ 2**ADDR_WIDTH-1.
- `CLEAR_VALUE`, 0, data written to every cleared location.
- `i_Bus_Clk`  in  1  single clock; all state changes on its rising edge.
- `i_Bus_Rst`  in  1  reset, asynchronous, active-high.
- `i_AC_Start`  in  1  level from the autoclear start bit; stays high until done or stop.
- `o_AC_Done`  out  1  one-cycle pulse when the clear completes; feeds autoclear `i_AC_Done`.
- `o_Busy`  out  1  high while a clear is in progress, and during the done cycle.
- `i_User_Wr_DV`  in  1  user write request.
- `i_User_Wr_Addr`  in  ADDR_WIDTH  user write address.
- `i_User_Wr_Data`  in  DATA_WIDTH  user write data.
- `o_User_Wr_Ready`  out  1  the user write is accepted in a cycle where DV and Ready are both high.
- `o_Mem_Wr_En`  out  1  RAM write request.
- `o_Mem_Wr_Addr`  out  ADDR_WIDTH  RAM write address.
- `o_Mem_Wr_Data`  out  DATA_WIDTH  RAM write data.
- `i_Mem_Wr_Ready`  in  1  the RAM accepts the write in a cycle where En and Ready are both high; may stall arbitrarily.

## Operation
- Start detect:
  - `r_Start_Q` holds the registered `i_AC_Start`.
  - `w_Start_Edge = i_AC_Start & ~r_Start_Q`.
  - Only a rising edge starts a clear. A level still high after done cannot restart.
- States:
  - IDLE:
    - Mem port is driven combinationally from the user port.
    - `o_Mem_Wr_En = i_User_Wr_DV`; addr and data pass through.
    - `o_User_Wr_Ready = i_Mem_Wr_Ready`.
    - On `w_Start_Edge`: go to CLEAR and load counter 0.
  - CLEAR:
    - `o_Mem_Wr_En=1`, `o_Mem_Wr_Addr=r_Count`, `o_Mem_Wr_Data=CLEAR_VALUE`.
    - `o_User_Wr_Ready=0`.
    - On accept (`i_Mem_Wr_Ready`): if `r_Count==LAST_ADDR`, go to DONE; else `r_Count+1`.
    - If `i_AC_Start==0` in any CLEAR cycle: go to IDLE with no done pulse. The current write is dropped if not accepted that cycle.
    - Abort has priority over completion in the same cycle.
  - DONE:
    - `o_AC_Done=1`, `o_Mem_Wr_En=0`, `o_User_Wr_Ready=0`.
    - Go to IDLE unconditionally.
- `o_Busy` = state != IDLE.
- Counter is ADDR_WIDTH bits and never wraps: the compare to `LAST_ADDR` happens before increment.
- A user write accepted in the edge cycle completes. The clear begins the next cycle, so a user write is never interleaved with clear writes.
- A user write pending when CLEAR begins waits until IDLE returns.

## Timing
- Reset values:
  - State IDLE, `r_Count=0`, `r_Start_Q=1`. A start already high at reset release does not trigger a clear.
  - `o_AC_Done=0`, `o_Busy=0`.
  - Mem and user outputs follow the IDLE pass-through.
- Assertion of `i_Bus_Rst` mid-clear returns to IDLE immediately (async). No done pulse is issued and the RAM is left partially cleared.
- Latency with `i_Mem_Wr_Ready` always high:
  - Edge sampled at clock N.
  - Clear writes are presented in cycles N+1 … N+1+LAST_ADDR.
  - `o_AC_Done` is high in cycle N+2+LAST_ADDR.
- Each stalled cycle extends completion by one cycle.
- Done pulse width is exactly one clock.

## Structure
- Shared package `Bus_Mem_Pkg` holds the state enum `t_Clear_State {IDLE, CLEAR, DONE}`.
- No sub-module is needed. Edge detect, counter, FSM and output mux are kept in one module.

## Test plan
- Use ADDR_WIDTH=4, LAST_ADDR=15, CLEAR_VALUE=16'hA5A5, with a 16-word RAM model behind the mem port.
- Clear with Mem Ready held high:
  - Stimulus: preload RAM with 16'h1234, raise start.
  - Required: 16 writes of A5A5 to addresses 0..15 in consecutive cycles; a single-cycle `o_AC_Done` 17 cycles after the edge; `o_Busy` high for those 17 cycles.
- Stalled clear:
  - Stimulus: Mem Ready toggles every other cycle.
  - Required: each address is written exactly once, in order, and done comes only after address 15 is accepted.
- Stop mid-clear:
  - Stimulus: drop start after 5 accepted writes.
  - Required: addresses 0..4 equal A5A5 and 5..15 keep 1234; no done pulse; IDLE next cycle.
- User pass-through and stall:
  - Stimulus: user writes addr 3 = 16'h00FF in IDLE, then holds a DV for addr 7 during a clear.
  - Required: addr 3 is written with Ready=1. During the clear `o_User_Wr_Ready` stays 0. The addr 7 write lands only after done, so the final RAM[7] holds the user value.
- Start held high after done:
  - Stimulus: keep start high for 3 cycles after the done pulse.
  - Required: no second clear occurs. A later low→high transition starts a new clear.
- Reset mid-clear:
  - Stimulus: pulse `i_Bus_Rst` at address 8.
  - Required: outputs return to reset values immediately, with no done pulse. A start held high through reset does not start a clear until it goes low and then high again.

Source files
------------

// File: rtl/bus_mem_pkg.sv
// rtl/bus_mem_pkg.sv - shared state type for the memory clear engine
package Bus_Mem_Pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } t_Clear_State;

endpackage

// File: rtl/ac_mem_clear.sv
// rtl/ac_mem_clear.sv - walks a RAM write port writing CLEAR_VALUE on a start edge,
// passing the user write channel through to the RAM while idle
module ac_mem_clear
   import Bus_Mem_Pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 8,
   parameter int                    DATA_WIDTH  = 16,
   parameter int                    LAST_ADDR   = 2**ADDR_WIDTH-1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
)(
   input  logic                  i_Bus_Clk,
   input  logic                  i_Bus_Rst,
   input  logic                  i_AC_Start,
   output logic                  o_AC_Done,
   output logic                  o_Busy,
   input  logic                  i_User_Wr_DV,
   input  logic [ADDR_WIDTH-1:0] i_User_Wr_Addr,
   input  logic [DATA_WIDTH-1:0] i_User_Wr_Data,
   output logic                  o_User_Wr_Ready,
   output logic                  o_Mem_Wr_En,
   output logic [ADDR_WIDTH-1:0] o_Mem_Wr_Addr,
   output logic [DATA_WIDTH-1:0] o_Mem_Wr_Data,
   input  logic                  i_Mem_Wr_Ready
);

   localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(LAST_ADDR);

   t_Clear_State          r_State;
   t_Clear_State          w_Next_State;
   logic [ADDR_WIDTH-1:0] r_Count;
   logic                  r_Start_Q;
   logic                  w_Start_Edge;
   logic                  w_At_Last;
   logic                  w_Advance;

   assign w_Start_Edge = i_AC_Start & ~r_Start_Q;
   assign w_At_Last    = (r_Count == LP_LAST);
   // Compare happens before increment, so the counter never wraps past LAST_ADDR.
   assign w_Advance    = (r_State == CLEAR) & i_AC_Start & i_Mem_Wr_Ready & ~w_At_Last;
   assign o_Busy       = (r_State != IDLE);

   // r_Start_Q resets high so a start level already present at reset release is ignored.
   always_ff @(posedge i_Bus_Clk or posedge i_Bus_Rst) begin
      if (i_Bus_Rst) begin
         r_State   <= IDLE;
         r_Count   <= '0;
         r_Start_Q <= 1'b1;
      end else begin
         r_State   <= w_Next_State;
         r_Start_Q <= i_AC_Start;
         if ((r_State == IDLE) && w_Start_Edge) begin
            r_Count <= '0;
         end else if (w_Advance) begin
            r_Count <= r_Count + ADDR_WIDTH'(1);
         end
      end
   end

   always_comb begin
      w_Next_State    = r_State;
      o_Mem_Wr_En     = i_User_Wr_DV;
      o_Mem_Wr_Addr   = i_User_Wr_Addr;
      o_Mem_Wr_Data   = i_User_Wr_Data;
      o_User_Wr_Ready = i_Mem_Wr_Ready;
      o_AC_Done       = 1'b0;
      case (r_State)
         IDLE: begin
            if (w_Start_Edge) begin
               w_Next_State = CLEAR;
            end
         end
         CLEAR: begin
            o_Mem_Wr_En     = 1'b1;
            o_Mem_Wr_Addr   = r_Count;
            o_Mem_Wr_Data   = CLEAR_VALUE;
            o_User_Wr_Ready = 1'b0;
            // A dropped start wins over completing the last address.
            if (!i_AC_Start) begin
               w_Next_State = IDLE;
            end else if (i_Mem_Wr_Ready && w_At_Last) begin
               w_Next_State = DONE;
            end
         end
         DONE: begin
            o_Mem_Wr_En     = 1'b0;
            o_User_Wr_Ready = 1'b0;
            o_AC_Done       = 1'b1;
            w_Next_State    = IDLE;
         end
         default: begin
            w_Next_State = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ac_mem_clear.sv
// tb/tb_ac_mem_clear.sv - scoreboard bench for ac_mem_clear with a 16-word RAM behind the mem port
module tb_ac_mem_clear;

   localparam int              AW   = 4;
   localparam int              DW   = 16;
   localparam int              LAST = 15;
   localparam logic [DW-1:0]   CV   = 16'hA5A5;
   localparam logic [DW-1:0]   PRE  = 16'h1234;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } t_wr;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_AC_Start;
   logic          o_AC_Done;
   logic          o_Busy;
   logic          i_User_Wr_DV;
   logic [AW-1:0] i_User_Wr_Addr;
   logic [DW-1:0] i_User_Wr_Data;
   logic          o_User_Wr_Ready;
   logic          o_Mem_Wr_En;
   logic [AW-1:0] o_Mem_Wr_Addr;
   logic [DW-1:0] o_Mem_Wr_Data;
   logic          i_Mem_Wr_Ready;

   t_wr           exp_wr[$];
   int            exp_done_cyc[$];
   int            exp_done_acc[$];
   logic [DW-1:0] ram     [16];
   logic [DW-1:0] ref_mem [16];
   int            cyc = 0;
   int            n_acc = 0;
   int            n_pushed = 0;
   int            n_done = 0;
   int            busy_cycles = 0;
   int            n_cmp = 0;
   int            n_fail = 0;
   int            rdy_mode = 0;

   ac_mem_clear #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .LAST_ADDR  (LAST),
      .CLEAR_VALUE(CV)
   ) dut (
      .i_Bus_Clk      (clk),
      .i_Bus_Rst      (rst),
      .i_AC_Start     (i_AC_Start),
      .o_AC_Done      (o_AC_Done),
      .o_Busy         (o_Busy),
      .i_User_Wr_DV   (i_User_Wr_DV),
      .i_User_Wr_Addr (i_User_Wr_Addr),
      .i_User_Wr_Data (i_User_Wr_Data),
      .o_User_Wr_Ready(o_User_Wr_Ready),
      .o_Mem_Wr_En    (o_Mem_Wr_En),
      .o_Mem_Wr_Addr  (o_Mem_Wr_Addr),
      .o_Mem_Wr_Data  (o_Mem_Wr_Data),
      .i_Mem_Wr_Ready (i_Mem_Wr_Ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endfunction

   // RAM ready: 0 = always ready, 1 = toggles every cycle, 2 = random
   initial begin
      i_Mem_Wr_Ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            1:       i_Mem_Wr_Ready = ~i_Mem_Wr_Ready;
            2:       i_Mem_Wr_Ready = 1'($urandom_range(0, 1));
            default: i_Mem_Wr_Ready = 1'b1;
         endcase
      end
   end

   // Monitor: every accepted RAM write and every done pulse is matched against the queues.
   always @(negedge clk) begin
      t_wr e;
      int  dc;
      int  da;
      if (o_Busy) begin
         busy_cycles++;
         check("user_ready_while_busy", o_User_Wr_Ready, 0);
      end else begin
         check("user_ready_passthru", o_User_Wr_Ready, i_Mem_Wr_Ready);
      end
      if (o_Mem_Wr_En && i_Mem_Wr_Ready) begin
         n_acc++;
         if (exp_wr.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0d data %h, required no write", o_Mem_Wr_Addr, o_Mem_Wr_Data);
         end else begin
            e = exp_wr.pop_front();
            check("wr_addr", o_Mem_Wr_Addr, e.a);
            check("wr_data", o_Mem_Wr_Data, e.d);
         end
         ram[o_Mem_Wr_Addr] = o_Mem_Wr_Data;
      end
      if (o_AC_Done) begin
         n_done++;
         if (exp_done_cyc.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got pulse at cycle %0d, required none", cyc);
         end else begin
            dc = exp_done_cyc.pop_front();
            da = exp_done_acc.pop_front();
            if (dc >= 0) check("done_cycle", cyc, dc);
            check("done_after_writes", n_acc, da);
         end
      end
   end

   task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      t_wr w;
      w.a = a;
      w.d = d;
      exp_wr.push_back(w);
      n_pushed++;
      ref_mem[a] = d;
   endtask

   task automatic preload();
      for (int i = 0; i < 16; i++) begin
         ram[i]     = PRE;
         ref_mem[i] = PRE;
      end
   endtask

   task automatic start_clear(input int n_wr, input bit want_done, input bit fixed_lat);
      @(posedge clk); #1;
      i_AC_Start  = 1'b1;
      busy_cycles = 0;
      for (int a = 0; a < n_wr; a++) push_wr(AW'(a), CV);
      if (want_done) begin
         exp_done_cyc.push_back(fixed_lat ? cyc + LAST + 2 : -1);
         exp_done_acc.push_back(n_pushed);
      end
   endtask

   task automatic drop_start();
      @(posedge clk); #1;
      i_AC_Start = 1'b0;
   endtask

   task automatic wait_done(input int limit, input string name);
      int base;
      int k;
      base = n_done;
      k    = 0;
      while (n_done == base && k < limit) begin
         @(negedge clk);
         k++;
      end
      check({name, "_done_seen"}, n_done - base, 1);
   endtask

   task automatic wait_drain(input int limit, input string name);
      int k;
      k = 0;
      while (exp_wr.size() != 0 && k < limit) begin
         @(negedge clk);
         k++;
      end
      check({name, "_writes_drained"}, exp_wr.size(), 0);
   endtask

   task automatic user_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string name);
      int   k;
      logic acc;
      @(posedge clk); #1;
      i_User_Wr_DV   = 1'b1;
      i_User_Wr_Addr = a;
      i_User_Wr_Data = d;
      push_wr(a, d);
      k   = 0;
      acc = 1'b0;
      while (!acc && k < 400) begin
         @(negedge clk);
         acc = o_User_Wr_Ready;
         k++;
      end
      check({name, "_accepted"}, acc, 1);
      @(posedge clk); #1;
      i_User_Wr_DV = 1'b0;
   endtask

   task automatic compare_ram(input string name);
      for (int i = 0; i < 16; i++) check($sformatf("%s_ram[%0d]", name, i), ram[i], ref_mem[i]);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no end of test, required finish within time limit");
      $fatal(1);
   end

   initial begin
      int base;
      rst            = 1'b1;
      i_AC_Start     = 1'b1;
      i_User_Wr_DV   = 1'b0;
      i_User_Wr_Addr = '0;
      i_User_Wr_Data = '0;
      preload();

      repeat (2) @(negedge clk);
      check("rst_busy", o_Busy, 0);
      check("rst_done", o_AC_Done, 0);
      check("rst_mem_en", o_Mem_Wr_En, 0);
      check("rst_user_ready", o_User_Wr_Ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("start_high_at_reset_no_clear", o_Busy, 0);
      drop_start();

      // stop after 5 accepted writes: start falls while address 4 is presented
      start_clear(5, 1'b0, 1'b0);
      repeat (5) @(posedge clk); #1;
      i_AC_Start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_idle_next", o_Busy, 0);
      wait_drain(20, "abort");
      repeat (3) @(posedge clk);
      compare_ram("abort");

      // full clear with ready held high, start kept high past done
      preload();
      start_clear(16, 1'b1, 1'b1);
      wait_done(40, "full");
      repeat (3) @(posedge clk); #1;
      i_AC_Start = 1'b0;
      check("full_busy_cycles", busy_cycles, 17);
      repeat (4) @(posedge clk);
      wait_drain(10, "full");
      compare_ram("full");

      // user write in idle, then a user write held through a clear
      user_write(4'd3, 16'h00FF, "user_idle");
      start_clear(16, 1'b1, 1'b1);
      repeat (2) @(posedge clk);
      user_write(4'd7, 16'hBEEF, "user_stalled");
      drop_start();
      wait_drain(40, "user");
      compare_ram("user");

      // ready toggling every cycle
      rdy_mode = 1;
      start_clear(16, 1'b1, 1'b0);
      wait_done(100, "toggle");
      drop_start();
      wait_drain(20, "toggle");
      rdy_mode = 0;

      // random ready with random user traffic between clears
      for (int it = 0; it < 4; it++) begin
         rdy_mode = 2;
         repeat ($urandom_range(1, 3)) user_write(AW'($urandom_range(0, 15)), DW'($urandom), "user_rand");
         start_clear(16, 1'b1, 1'b0);
         wait_done(200, "rand");
         drop_start();
         repeat ($urandom_range(0, 2)) user_write(AW'($urandom_range(0, 15)), DW'($urandom), "user_rand_post");
         wait_drain(40, "rand");
      end
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      compare_ram("rand");

      // start drops in the same cycle the last address is accepted: no done
      preload();
      base = n_done;
      start_clear(16, 1'b0, 1'b0);
      repeat (16) @(posedge clk); #1;
      i_AC_Start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_last_no_done", n_done - base, 0);
      check("abort_last_idle", o_Busy, 0);
      wait_drain(10, "abort_last");
      compare_ram("abort_last");

      // reset while address 8 is presented, start held through reset
      preload();
      base = n_done;
      start_clear(8, 1'b0, 1'b0);
      repeat (9) @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rst_mid_busy", o_Busy, 0);
      check("rst_mid_done", o_AC_Done, 0);
      check("rst_mid_mem_en", o_Mem_Wr_En, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("rst_mid_no_restart", o_Busy, 0);
      check("rst_mid_no_done", n_done - base, 0);
      wait_drain(5, "rst_mid");
      compare_ram("rst_partial");
      drop_start();
      start_clear(16, 1'b1, 1'b1);
      wait_done(40, "after_rst");
      drop_start();
      wait_drain(10, "after_rst");
      compare_ram("after_rst");

      repeat (4) @(posedge clk);
      check("done_queue_empty", exp_done_cyc.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
